// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch and sequencing stage for a single-cycle RISC-V core.
// It owns the architectural PC. Words come from a small direct-mapped cache on a hit, or from a
// variable-latency memory over a req/ack handshake on a miss. After each fetch it drives a
// one-cycle commit strobe to the core.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned CACHE_LINES = 16,
  parameter int unsigned INDEX_BITS  = $clog2(CACHE_LINES)
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] pc_new,
  output logic [31:0] instr,
  output logic        commit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        halted,
  output logic        misaligned
);

  localparam int unsigned TagBits = 32 - INDEX_BITS - 2;
  localparam logic [31:0] InstrNop    = 32'h0000_0013;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  typedef enum logic [1:0] {StFetch, StWait, StExec, StHalt} state_e;

  state_e                 r_state;
  logic [31:0]            r_pc;
  logic [31:0]            r_instr;
  logic                   r_mem_req;
  logic [31:0]            r_mem_addr;
  logic                   r_halted;
  logic                   r_misaligned;
  // Set when a flush lands while a miss is outstanding; the returning word must not be cached.
  logic                   r_drop;

  logic [CACHE_LINES-1:0] r_valid;
  logic [TagBits-1:0]     r_tag  [CACHE_LINES];
  logic [31:0]            r_data [CACHE_LINES];

  logic [INDEX_BITS-1:0]  w_index;
  logic [TagBits-1:0]     w_tag;
  logic                   w_hit;
  logic                   w_fill;
  logic                   w_is_ebreak;
  logic                   w_pc_new_misaligned;

  assign w_index             = r_pc[INDEX_BITS+1:2];
  assign w_tag               = r_pc[31:INDEX_BITS+2];
  assign w_hit               = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_fill              = (r_state == StWait) && mem_ack && !r_drop;
  assign w_is_ebreak         = (r_instr == InstrEbreak);
  assign w_pc_new_misaligned = (pc_new[1:0] != 2'b00);

  // Valid bits: reset and flush clear everything; flush beats a same-cycle fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= mem_rdata;
    end
  end

  // Sequencing FSM: fetch (hit or miss), wait for memory, execute, or halt for good.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StFetch;
      r_pc         <= RESET_PC;
      r_instr      <= InstrNop;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      case (r_state)
        StFetch: begin
          if (w_hit) begin
            r_instr <= r_data[w_index];
            r_state <= StExec;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= StWait;
          end
        end
        StWait: begin
          if (mem_ack) begin
            r_instr   <= mem_rdata;
            r_mem_req <= 1'b0;
            r_drop    <= 1'b0;
            r_state   <= StExec;
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        StExec: begin
          if (w_is_ebreak) begin
            r_halted <= 1'b1;
            r_state  <= StHalt;
          end else if (w_pc_new_misaligned) begin
            r_halted     <= 1'b1;
            r_misaligned <= 1'b1;
            r_state      <= StHalt;
          end else begin
            r_pc    <= pc_new;
            r_state <= StFetch;
          end
        end
        StHalt: begin
          r_mem_req <= 1'b0;
        end
        default: begin
          r_state <= StHalt;
        end
      endcase
    end
  end

  // Commit is combinational so the core sees it during the execute cycle itself.
  always_comb begin
    commit = 1'b0;
    if (r_state == StExec) begin
      commit = !w_is_ebreak && !w_pc_new_misaligned;
    end
  end

  assign pc         = r_pc;
  assign instr      = r_instr;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign halted     = r_halted;
  assign misaligned = r_misaligned;

endmodule
